// File: rtl/dualrail_chan_pkg.sv
// Shared types and helpers for the dual-rail channel sink: FSM states,
// enable polarity and per-digit classification over zero-padded rail vectors.
package dualrail_chan_pkg;

  typedef enum logic [1:0] {
    ACCEPT,
    WAIT_NEUTRAL,
    STALL,
    ERROR
  } chan_state_t;

  localparam int unsigned MAX_DIGITS = 64;
  typedef logic [MAX_DIGITS-1:0] digits_t;

  function automatic logic e_req_level(input bit e_active_low);
    return e_active_low ? 1'b0 : 1'b1;
  endfunction

  // Rails are zero-extended, so padding digits read as neutral; only
  // all_valid needs to mask them out.
  function automatic logic all_valid(input digits_t s0, input digits_t s1,
                                     input int unsigned nbits);
    digits_t mask;
    mask = '0;
    for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
      if (i < nbits) mask[i] = 1'b1;
    end
    return &((s0 ^ s1) | ~mask);
  endfunction

  function automatic logic all_neutral(input digits_t s0, input digits_t s1);
    return ~|(s0 | s1);
  endfunction

  function automatic logic any_illegal(input digits_t s0, input digits_t s1);
    return |(s0 & s1);
  endfunction

endpackage

// File: rtl/dualrail_chan_sink_sync_fifo.sv
// First-word fall-through token FIFO; out-of-range push/pop requests are ignored.
module sync_fifo_fwft #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           data,
  output logic                       valid,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_eff;
  logic             pop_eff;

  assign valid    = (count != '0);
  assign pop_eff  = pop && valid;
  assign push_eff = push && (count != CW'(DEPTH));
  assign data     = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push_eff) mem[wr_ptr] <= wdata;
  end

  // DEPTH is a power of two, so pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_eff) wr_ptr <= wr_ptr + AW'(1);
      if (pop_eff)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_eff, pop_eff})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dualrail_chan_sink_sync.sv
// Synchronous sink for a 4-phase dual-rail channel: rail synchronizer,
// handshake FSM driving e, and a valid/ready token FIFO.
module dualrail_chan_sink_sync
  import dualrail_chan_pkg::*;
#(
  parameter int unsigned NBITS        = 1,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned E_ACTIVE_LOW = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NBITS-1:0]           d0,
  input  logic [NBITS-1:0]           d1,
  output logic                       e,
  output logic [NBITS-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       error
);

  localparam int unsigned CW    = $clog2(DEPTH+1);
  localparam logic        E_REQ = e_req_level(E_ACTIVE_LOW != 0);

  logic [NBITS-1:0] sync0 [SYNC_STAGES];
  logic [NBITS-1:0] sync1 [SYNC_STAGES];
  logic [NBITS-1:0] s0, s1, prev0, prev1;
  logic             stable, tok_valid, tok_neutral, tok_illegal, push;
  chan_state_t      state;

  assign s0 = sync0[SYNC_STAGES-1];
  assign s1 = sync1[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync0[i] <= '0;
        sync1[i] <= '0;
      end
      prev0 <= '0;
      prev1 <= '0;
    end else begin
      sync0[0] <= d0;
      sync1[0] <= d1;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync0[i] <= sync0[i-1];
        sync1[i] <= sync1[i-1];
      end
      prev0 <= s0;
      prev1 <= s1;
    end
  end

  // Requiring two equal consecutive samples filters skew between digits.
  assign stable      = (s0 == prev0) && (s1 == prev1);
  assign tok_valid   = all_valid(digits_t'(s0), digits_t'(s1), NBITS);
  assign tok_neutral = all_neutral(digits_t'(s0), digits_t'(s1));
  assign tok_illegal = any_illegal(digits_t'(s0), digits_t'(s1));
  assign push        = (state == ACCEPT) && stable && tok_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACCEPT;
      e     <= E_REQ;
      error <= 1'b0;
    end else if (state != ERROR && stable && tok_illegal) begin
      state <= ERROR;
      e     <= ~E_REQ;
      error <= 1'b1;
    end else begin
      case (state)
        ACCEPT: begin
          if (push) begin
            state <= WAIT_NEUTRAL;
            e     <= ~E_REQ;
          end
        end
        WAIT_NEUTRAL: begin
          if (stable && tok_neutral) begin
            if (count < CW'(DEPTH)) begin
              state <= ACCEPT;
              e     <= E_REQ;
            end else begin
              state <= STALL;
            end
          end
        end
        STALL: begin
          if (count < CW'(DEPTH)) begin
            state <= ACCEPT;
            e     <= E_REQ;
          end
        end
        ERROR: state <= ERROR;
        default: begin
          state <= ERROR;
          e     <= ~E_REQ;
          error <= 1'b1;
        end
      endcase
    end
  end

  sync_fifo_fwft #(
    .WIDTH(NBITS),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .wdata(s1),
    .pop  (out_ready),
    .data (out_data),
    .valid(out_valid),
    .count(count)
  );

endmodule
